// File: rtl/codec_seq_pkg.sv
// Shared definitions for the DCT block sequencer.
//   seq_state_t : sequencer FSM states
//   BLK_COEFS   : coefficients per 8x8 block
//   ZIGZAG      : JPEG zigzag order, entry k = {v[2:0], u[2:0]} of the k-th index
//                 (u = column, v = row), used when ZIGZAG_SCAN_EN is defined
package codec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int BLK_COEFS = 64;

    // {v,u} packed as row*8+col, so each entry is simply the raster address.
    localparam logic [5:0] ZIGZAG [BLK_COEFS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/scan_pos_counter.sv
// 6-bit scan position counter for one 8x8 block.
//   clk  : clock
//   rst  : asynchronous active-low reset (p -> 0)
//   clr  : synchronous clear, has priority over en
//   en   : advance p by one (wraps 63 -> 0)
//   p    : current scan position
//   tc   : terminal count, p == 63
module scan_pos_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] p,
    output logic       tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= 6'd0;
        end else if (clr) begin
            p <= 6'd0;
        end else if (en) begin
            p <= p + 6'd1;
        end
    end

    assign tc = (p == 6'd63);

endmodule

// File: rtl/dct_block_sequencer.sv
// Control FSM that walks one 8x8 block through the DCT/quant datapath:
// accepts a block, issues 64 (u,v) index requests with valid/ready, waits out
// the datapath latency, pulses blk_done and tracks the block index in a frame.
//
// Build option: define ZIGZAG_SCAN_EN for JPEG zigzag order, otherwise raster.
//
// Ports:
//   clk, rst (async active-low)      abort      : sync return to IDLE, clears count
//   blk_valid / blk_ready            : block offer handshake
//   coef_valid / coef_ready, u, v    : index request handshake
//   coef_last                        : 64th index of the block
//   blk_done                         : one-cycle completion pulse
//   blk_idx                          : block index within frame
//   frame_done                       : with blk_done on the last block of a frame
module dct_block_sequencer
    import codec_seq_pkg::*;
#(
    parameter  int PIPE_LAT   = 4,
    parameter  int NUM_BLOCKS = 64,
    localparam int BLK_W      = $clog2(NUM_BLOCKS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic             coef_valid,
    input  logic             coef_ready,
    output logic [2:0]       u,
    output logic [2:0]       v,
    output logic             coef_last,
    output logic             blk_done,
    output logic [BLK_W-1:0] blk_idx,
    output logic             frame_done
);

    localparam int               FLUSH_INIT = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_INIT);
    localparam logic [BLK_W-1:0] LAST_BLK   = BLK_W'(NUM_BLOCKS - 1);

    seq_state_t state, state_nxt;
    logic [3:0] flush_cnt;
    logic [5:0] p;
    logic       p_tc;
    logic       accept;
    logic       coef_hs;

    assign accept  = (state == IDLE) && blk_valid;
    assign coef_hs = (state == RUN) && coef_ready;

    scan_pos_counter u_scan (
        .clk (clk),
        .rst (rst),
        .clr (abort | accept),
        .en  (coef_hs),
        .p   (p),
        .tc  (p_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (blk_valid) state_nxt = RUN;
            RUN:   if (coef_ready && p_tc) state_nxt = (PIPE_LAT > 0) ? FLUSH : DONE;
            FLUSH: if (flush_cnt == 4'd0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Loaded on RUN->FLUSH so the FLUSH state lasts exactly PIPE_LAT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 4'd0;
        end else if (abort) begin
            flush_cnt <= 4'd0;
        end else if (state == RUN && state_nxt == FLUSH) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == FLUSH && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blk_idx <= '0;
        end else if (abort) begin
            blk_idx <= '0;
        end else if (state == DONE) begin
            blk_idx <= (blk_idx == LAST_BLK) ? '0 : blk_idx + 1'b1;
        end
    end

    assign blk_ready  = (state == IDLE);
    assign coef_valid = (state == RUN);
    assign coef_last  = (state == RUN) && p_tc;
    assign blk_done   = (state == DONE);
    assign frame_done = (state == DONE) && (blk_idx == LAST_BLK);

`ifdef ZIGZAG_SCAN_EN
    assign {v, u} = ZIGZAG[p];
`else
    assign {v, u} = p;
`endif

endmodule

// File: tb/tb_dct_block_sequencer.sv
module tb_dct_block_sequencer;

    localparam int PIPE_LAT   = 4;
    localparam int NUM_BLOCKS = 4;
    localparam int BLK_W      = $clog2(NUM_BLOCKS);

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic             blk_valid;
    logic             blk_ready;
    logic             coef_valid;
    logic             coef_ready;
    logic [2:0]       u;
    logic [2:0]       v;
    logic             coef_last;
    logic             blk_done;
    logic [BLK_W-1:0] blk_idx;
    logic             frame_done;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] sb[$];
    logic [5:0] order[64];
    int         exp_idx = 0;

    always #5 clk = ~clk;

    dct_block_sequencer #(
        .PIPE_LAT   (PIPE_LAT),
        .NUM_BLOCKS (NUM_BLOCKS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .abort      (abort),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .u          (u),
        .v          (v),
        .coef_last  (coef_last),
        .blk_done   (blk_done),
        .blk_idx    (blk_idx),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    // stop_at >= 0: return early once that many indices were accepted.
    task automatic run_block(input bit rnd, input int stop_at);
        int         cyc;
        int         hs;
        int         stalls;
        bit         was_stall;
        bit         done;
        bit         seen[64];
        logic [6:0] prev;
        logic [6:0] e;
        check("accept_ready", blk_ready, 1);
        blk_valid = 1'b1;
        @(posedge clk);
        #1 blk_valid = 1'b0;
        for (int k = 0; k < 64; k++) sb.push_back({k == 63, order[k]});
        for (int k = 0; k < 64; k++) seen[k] = 1'b0;
        hs = 0; stalls = 0; was_stall = 1'b0; done = 1'b0; cyc = 1; prev = '0;
        @(negedge clk);
        while (!done && cyc < 400) begin
            if (blk_done) begin
                check("done_cycle", cyc, 65 + PIPE_LAT + stalls);
                check("done_blk_idx", blk_idx, exp_idx);
                check("frame_done", frame_done, exp_idx == NUM_BLOCKS - 1);
                check("sb_empty", sb.size(), 0);
                check("handshakes", hs, 64);
                done = 1'b1;
            end else begin
                check("busy_ready", blk_ready, 0);
                check("busy_frame_done", frame_done, 0);
                if (coef_valid) begin
                    if (stop_at >= 0 && hs == stop_at) begin
                        coef_ready = 1'b0;
                        return;
                    end
                    if (was_stall) check("stall_hold", {coef_last, v, u}, prev);
                    prev = {coef_last, v, u};
                    coef_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (coef_ready) begin
                        check("sb_nonempty", sb.size() > 0, 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("coef", {coef_last, v, u}, e);
                        end
                        check("seen_once", seen[{v, u}], 0);
                        seen[{v, u}] = 1'b1;
                        hs++;
                        was_stall = 1'b0;
                    end else begin
                        stalls++;
                        was_stall = 1'b1;
                    end
                end else begin
                    coef_ready = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", done, 1);
        coef_ready = 1'b0;
        if (done) begin
            exp_idx = (exp_idx + 1) % NUM_BLOCKS;
            @(negedge clk);
            check("post_ready", blk_ready, 1);
            check("post_done_low", blk_done, 0);
            check("post_blk_idx", blk_idx, exp_idx);
        end
    endtask

    initial begin
        int k;
        int lo;
        int hi;
        int pulses;
`ifdef ZIGZAG_SCAN_EN
        k = 0;
        for (int d = 0; d < 15; d++) begin
            lo = (d > 7) ? d - 7 : 0;
            hi = (d < 7) ? d : 7;
            if (d % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin order[k] = 6'(r * 8 + (d - r)); k++; end
            end else begin
                for (int r = hi; r >= lo; r--) begin order[k] = 6'(r * 8 + (d - r)); k++; end
            end
        end
`else
        for (int i = 0; i < 64; i++) order[i] = 6'(i);
`endif

        rst = 1'b0; abort = 1'b0; blk_valid = 1'b0; coef_ready = 1'b0;
        #12;
        check("rst_ready", blk_ready, 1);
        check("rst_valid", coef_valid, 0);
        check("rst_uv", {v, u}, 0);
        check("rst_last", coef_last, 0);
        check("rst_done", blk_done, 0);
        check("rst_frame", frame_done, 0);
        check("rst_idx", blk_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Four blocks back-to-back: frame_done only on the fourth, idx wraps.
        run_block(1'b0, -1);
        run_block(1'b1, -1);
        run_block(1'b0, -1);
        run_block(1'b1, -1);
        check("wrap_idx", blk_idx, 0);
        run_block(1'b0, -1);

        // Abort at p=30.
        run_block(1'b0, 30);
        check("pre_abort_uv", {v, u}, {1'b0, order[30]});
        abort = 1'b1; coef_ready = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0; coef_ready = 1'b0;
        @(negedge clk);
        check("abort_ready", blk_ready, 1);
        check("abort_valid", coef_valid, 0);
        check("abort_idx", blk_idx, 0);
        check("abort_uv", {v, u}, 0);
        sb.delete();
        exp_idx = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (blk_done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);

        // Abort coinciding with an accept discards the block.
        blk_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 blk_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("discard_ready", blk_ready, 1);
        check("discard_valid", coef_valid, 0);
        run_block(1'b0, -1);

        // Asynchronous reset between edges in the middle of RUN.
        run_block(1'b1, 10);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", coef_valid, 0);
        check("arst_uv", {v, u}, 0);
        check("arst_ready", blk_ready, 1);
        check("arst_idx", blk_idx, 0);
        sb.delete();
        exp_idx = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_block(1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_block_sequencer.md
# dct_block_sequencer

Control FSM that walks one 8x8 block through the transform/quantisation datapath of the image codec. For every accepted block it produces the 64 (u, v) coefficient indices in order with a valid/ready handshake and waits out the datapath pipeline latency. It then signals block completion and tracks the block position within a frame. It sits between the block-fetch front end and the DCT/quant datapath, and owns all index sequencing for that datapath.

## Interface
Parameters:
- PIPE_LAT, default 4: datapath latency in cycles from the last index handshake to the last result; range 0..15.
- NUM_BLOCKS, default 64: blocks per frame; range 2..4096.
- BLK_W (localparam) = $clog2(NUM_BLOCKS).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
- abort  in  1  synchronous abort: return to IDLE and clear block count.
- blk_valid  in  1  front end offers a new block.
- blk_ready  out  1  sequencer can accept a block.
- coef_valid  out  1  u/v are a valid index request.
- coef_ready  in  1  datapath accepts the current index.
- u  out  3  horizontal frequency index.
- v  out  3  vertical frequency index.
- coef_last  out  1  current index is the 64th of the block.
- blk_done  out  1  one-cycle pulse: block fully processed.
- blk_idx  out  BLK_W  index of the current or last block within the frame.
- frame_done  out  1  one-cycle pulse with blk_done on the last block of a frame.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: blk_ready=1 and coef_valid=0. On blk_valid&blk_ready, the scan position is cleared to 0 and the FSM enters RUN.
- RUN: coef_valid=1. u/v come from a 6-bit scan position p, mapped through the scan order (see Configuration).
  - p advances only on coef_valid&coef_ready; u/v/coef_last hold while stalled.
  - coef_last=1 when p=63.
  - A handshake at p=63 moves the FSM to FLUSH if PIPE_LAT>0, otherwise directly to DONE.
- FLUSH: a down-counter is loaded with PIPE_LAT-1 on entry. The FSM moves to DONE when the counter reads 0. coef_valid=0. coef_ready is ignored.
- DONE: blk_done=1 for exactly this one cycle, then the FSM returns to IDLE.
  - blk_idx increments at the end of DONE and wraps from NUM_BLOCKS-1 to 0.
  - frame_done=1 in DONE when blk_idx=NUM_BLOCKS-1.
- abort has priority over every transition. The next state is IDLE; p, the flush counter and blk_idx clear to 0; no blk_done pulse is produced. An abort in the same cycle as a blk_valid handshake discards the block.
- Reset values: state IDLE, p=0, blk_idx=0. Outputs during reset: u=v=0, coef_valid=0, coef_last=0, blk_done=0, frame_done=0, blk_ready=1.
- blk_ready, coef_valid, coef_last and blk_done are decoded combinationally from registered state only. There is no combinational path from coef_ready or blk_valid to any output.

## Timing
- Block accepted at edge T: first index (u=0, v=0) is valid in cycle T+1.
- With coef_ready held at 1:
  - indices are presented in T+1..T+64, with coef_last in T+64;
  - FLUSH occupies T+65..T+64+PIPE_LAT;
  - blk_done is high in T+65+PIPE_LAT;
  - blk_ready returns to 1 in T+66+PIPE_LAT.
- Every stall cycle (coef_ready=0 in RUN) delays all later events by exactly one cycle.
- Minimum block period is 66+PIPE_LAT cycles. Back-to-back blocks are not overlapped.

## Configuration
- ZIGZAG_SCAN_EN defined: p is mapped through a 64-entry JPEG zigzag table. The sequence is (0,0), (1,0), (0,1), (0,2), (1,1), (2,0), …, ending at (7,7), with u = column and v = row.
- ZIGZAG_SCAN_EN undefined: raster order, u = p[2:0] and v = p[5:3], i.e. (0,0), (1,0), …, (7,0), (0,1), …, (7,7).
- Handshake, FSM and timing are identical in both builds. In both builds coef_last coincides with (7,7).

## Structure
- Package codec_seq_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - the constant BLK_COEFS=64;
  - the zigzag lookup table, 64 entries of {v[2:0], u[2:0]}.
- Sub-module scan_pos_counter: 6-bit counter with clear, enable and terminal-count (p=63) output, reset asynchronously to 0. The FSM, flush counter and block counter stay in dct_block_sequencer.

## Test plan
- Raster build, PIPE_LAT=4, coef_ready=1: one block. Expect 64 indices (0,0)…(7,7), coef_last only on (7,7), blk_done 69 cycles after the accept edge, and blk_idx 0→1.
- Zigzag build: one block. Expect the first six indices (0,0), (1,0), (0,1), (0,2), (1,1), (2,0), the last index (7,7), and all 64 positions seen exactly once.
- Random coef_ready (50% duty). Expect u/v/coef_last stable while stalled, no index skipped or repeated, and blk_done delayed by exactly the stall count.
- NUM_BLOCKS=4, four blocks back-to-back. Expect frame_done only with the 4th blk_done, blk_idx wrapping to 0, and blk_ready low from accept until one cycle after blk_done.
- abort asserted at p=30, then a new block accepted. Expect the next-cycle state IDLE, no blk_done, blk_idx=0, and the new block starting at (0,0).
- rst asserted mid-RUN (asynchronously, between edges). Expect coef_valid=0 and u=v=0 immediately, blk_ready=1, and normal operation after release.
